// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects and
// freeze FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // EX has two source operands: index 0 is rs (operand a), index 1 is rt (operand b)
  localparam int NUM_OPS = 2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline <-> hazard controller bundle. The pipeline side is the master: it
// presents stage fields and consumes the stall/flush/forward controls.
interface hazard_ctrl_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              ex_mem_to_reg;
  logic [REG_AW-1:0] ex_wr_reg;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic              ex_branch_tkn;
  logic              mem_reg_write;
  logic              mem_mem_to_reg;
  logic [REG_AW-1:0] mem_wr_reg;
  logic              mem_ready;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_wr_reg;
  logic              cnt_clr;

  logic              stall_pc;
  logic              stall_if_id;
  logic              bubble_id_ex;
  logic              flush_if_id;
  logic              freeze;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt,
    output ex_mem_to_reg, ex_wr_reg, ex_rs, ex_rt, ex_branch_tkn,
    output mem_reg_write, mem_mem_to_reg, mem_wr_reg, mem_ready,
    output wb_reg_write, wb_wr_reg, cnt_clr,
    input  stall_pc, stall_if_id, bubble_id_ex, flush_if_id, freeze,
    input  fwd_a, fwd_b, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt,
    input  ex_mem_to_reg, ex_wr_reg, ex_rs, ex_rt, ex_branch_tkn,
    input  mem_reg_write, mem_mem_to_reg, mem_wr_reg, mem_ready,
    input  wb_reg_write, wb_wr_reg, cnt_clr,
    output stall_pc, stall_if_id, bubble_id_ex, flush_if_id, freeze,
    output fwd_a, fwd_b, stall_cycles
  );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one EX operand. A load in MEM has no data yet, so it
// is never a forwarding source; MEM beats WB because it is the younger write.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int ZERO_SKIP = 1
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_mem_reg_write,
  input  logic              i_mem_mem_to_reg,
  input  logic [REG_AW-1:0] i_mem_wr_reg,
  input  logic              i_wb_reg_write,
  input  logic [REG_AW-1:0] i_wb_wr_reg,
  output logic [1:0]        o_sel
);

  logic w_src_ok;

  assign w_src_ok = !((ZERO_SKIP != 0) && (i_src == '0));

  always_comb begin
    o_sel = FWD_RF;
    if (w_src_ok) begin
      if (i_mem_reg_write && !i_mem_mem_to_reg && (i_mem_wr_reg == i_src))
        o_sel = FWD_MEM;
      else if (i_wb_reg_write && (i_wb_wr_reg == i_src))
        o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// 5-stage pipeline hazard controller: load-use stall, multi-cycle load freeze,
// taken-branch flush, EX forwarding selects and a saturating stall counter.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int MEM_LAT   = 1,
  parameter int CNT_W     = 16,
  parameter int ZERO_SKIP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_ctrl_unit_if.slave  hz
);

  localparam bit FSM_EN = (MEM_LAT > 1);
  localparam int WCW    = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
  // Trigger cycle already counts as one freeze cycle, hence MEM_LAT-2 more
  localparam logic [WCW-1:0] WAIT_INIT = WCW'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

  hz_state_e        r_state, w_state_nxt;
  logic [WCW-1:0]   r_wcnt, w_wcnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_ex_wr_ok, w_load_use, w_freeze, w_branch, w_stall;

  logic [NUM_OPS-1:0][REG_AW-1:0] w_src;
  logic [NUM_OPS-1:0][1:0]        w_sel;

  // ---------------- load-use detect ----------------
  assign w_ex_wr_ok = !((ZERO_SKIP != 0) && (hz.ex_wr_reg == '0));
  assign w_load_use = hz.ex_mem_to_reg && w_ex_wr_ok &&
                      ((hz.id_use_rs && (hz.ex_wr_reg == hz.id_rs)) ||
                       (hz.id_use_rt && (hz.ex_wr_reg == hz.id_rt)));

  // ---------------- load freeze FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_freeze    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (FSM_EN && hz.mem_mem_to_reg && !hz.mem_ready) begin
          w_freeze    = 1'b1;
          w_state_nxt = ST_WAIT;
          w_wcnt_nxt  = WAIT_INIT;
        end
      end
      ST_WAIT: begin
        // Exit cycle is unfrozen so the load leaves MEM on this edge
        if ((r_wcnt == '0) || hz.mem_ready) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_freeze   = 1'b1;
          w_wcnt_nxt = r_wcnt - 1'b1;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // ---------------- priority: freeze > branch > load-use ----------------
  assign w_branch = hz.ex_branch_tkn && !w_freeze;
  assign w_stall  = w_load_use && !w_freeze && !hz.ex_branch_tkn;

  assign hz.freeze       = rst_n && w_freeze;
  assign hz.stall_pc     = rst_n && w_stall;
  assign hz.stall_if_id  = rst_n && w_stall;
  assign hz.flush_if_id  = rst_n && w_branch;
  assign hz.bubble_id_ex = rst_n && (w_branch || w_stall);

  // ---------------- forwarding ----------------
  assign w_src = {hz.ex_rt, hz.ex_rs};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    hazard_fwd_sel #(
      .REG_AW    (REG_AW),
      .ZERO_SKIP (ZERO_SKIP)
    ) u_fwd (
      .i_src            (w_src[g]),
      .i_mem_reg_write  (hz.mem_reg_write),
      .i_mem_mem_to_reg (hz.mem_mem_to_reg),
      .i_mem_wr_reg     (hz.mem_wr_reg),
      .i_wb_reg_write   (hz.wb_reg_write),
      .i_wb_wr_reg      (hz.wb_wr_reg),
      .o_sel            (w_sel[g])
    );
  end

  assign hz.fwd_a = rst_n ? w_sel[0] : FWD_RF;
  assign hz.fwd_b = rst_n ? w_sel[1] : FWD_RF;

  // ---------------- stall-cycle counter ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (hz.cnt_clr)
      r_stall_cnt <= '0;
    else if ((w_freeze || w_stall) && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign hz.stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit (MEM_LAT=4, CNT_W=4): vector table, hand-built
// freeze/branch/reset/saturation sequences, then random traffic vs a model.
module tb_hazard_ctrl_unit;
  localparam int AW  = 5;
  localparam int LAT = 4;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_unit_if #(.REG_AW(AW), .CNT_W(CW)) hif ();

  hazard_ctrl_unit #(
    .REG_AW(AW), .MEM_LAT(LAT), .CNT_W(CW), .ZERO_SKIP(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif.slave)
  );

  typedef struct packed {
    logic [AW-1:0] id_rs, id_rt;
    logic          use_rs, use_rt, ex_m2r;
    logic [AW-1:0] ex_wr, ex_rs, ex_rt;
    logic          br, mem_rw, mem_m2r;
    logic [AW-1:0] mem_wr;
    logic          rdy, wb_rw;
    logic [AW-1:0] wb_wr;
    logic          clr;
  } in_t;

  // expected = {stall_pc, stall_if_id, bubble_id_ex, flush_if_id, freeze, fwd_a, fwd_b}
  typedef struct {
    string      name;
    in_t        i;
    logic [8:0] e;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {hif.stall_pc, hif.stall_if_id, hif.bubble_id_ex, hif.flush_if_id,
            hif.freeze, hif.fwd_a, hif.fwd_b};
  endfunction

  task automatic drive(input in_t v);
    hif.id_rs = v.id_rs;           hif.id_rt = v.id_rt;
    hif.id_use_rs = v.use_rs;      hif.id_use_rt = v.use_rt;
    hif.ex_mem_to_reg = v.ex_m2r;  hif.ex_wr_reg = v.ex_wr;
    hif.ex_rs = v.ex_rs;           hif.ex_rt = v.ex_rt;
    hif.ex_branch_tkn = v.br;      hif.mem_reg_write = v.mem_rw;
    hif.mem_mem_to_reg = v.mem_m2r; hif.mem_wr_reg = v.mem_wr;
    hif.mem_ready = v.rdy;         hif.wb_reg_write = v.wb_rw;
    hif.wb_wr_reg = v.wb_wr;       hif.cnt_clr = v.clr;
  endtask

  // Inputs change just after the edge; caller checks at the following negedge
  task automatic cyc(input in_t v);
    @(posedge clk);
    #1 drive(v);
    @(negedge clk);
  endtask

  function automatic logic [1:0] ref_fwd(input logic [AW-1:0] s, input in_t v);
    if (s == 0) return 2'b00;
    if (v.mem_rw && !v.mem_m2r && v.mem_wr == s) return 2'b10;
    if (v.wb_rw && v.wb_wr == s) return 2'b01;
    return 2'b00;
  endfunction

  // age: -1 = no load waiting, else cycles since the stuck load first froze MEM
  function automatic void ref_model(input in_t v, input int age,
                                    output logic [8:0] e, output int nage, output bit inc);
    bit lu, f, st;
    lu = v.ex_m2r && v.ex_wr != 0 &&
         ((v.use_rs && v.ex_wr == v.id_rs) || (v.use_rt && v.ex_wr == v.id_rt));
    if (age < 0) f = (LAT > 1) && v.mem_m2r && !v.rdy;
    else         f = !v.rdy && (age < LAT - 1);
    nage = f ? ((age < 0) ? 1 : age + 1) : -1;
    st   = !f && !v.br && lu;
    e    = {st, st, !f && (v.br || lu), !f && v.br, f, ref_fwd(v.ex_rs, v), ref_fwd(v.ex_rt, v)};
    inc  = f || st;
  endfunction

  initial begin
    in_t v, idle, lu, trig;
    logic [8:0] e;
    int age, nage, mcnt;
    bit inc;

    idle = '0;
    lu = '0; lu.ex_m2r = 1; lu.ex_wr = 2; lu.id_rs = 2; lu.use_rs = 1; lu.id_rt = 4;
    trig = '0; trig.mem_m2r = 1; trig.rdy = 0;

    // ---------- vector table ----------
    v = idle;                              tbl.push_back('{"idle", v, 9'b00000_00_00});
    v = lu;                                tbl.push_back('{"lu_rs", v, 9'b11100_00_00});
    v = lu; v.use_rs = 0;                  tbl.push_back('{"lu_no_use", v, 9'b00000_00_00});
    v = lu; v.ex_wr = 0; v.id_rs = 0;      tbl.push_back('{"lu_r0", v, 9'b00000_00_00});
    v = idle; v.ex_m2r = 1; v.ex_wr = 6; v.id_rt = 6; v.use_rt = 1;
                                           tbl.push_back('{"lu_rt", v, 9'b11100_00_00});
    v = lu; v.ex_m2r = 0;                  tbl.push_back('{"no_load", v, 9'b00000_00_00});
    v = lu; v.br = 1;                      tbl.push_back('{"br_lu", v, 9'b00110_00_00});
    v = idle; v.mem_rw = 1; v.mem_wr = 5; v.ex_rs = 5;
                                           tbl.push_back('{"fwd_a_mem", v, 9'b00000_10_00});
    v = idle; v.mem_rw = 1; v.mem_wr = 7; v.wb_rw = 1; v.wb_wr = 7; v.ex_rt = 7;
                                           tbl.push_back('{"fwd_b_mem_wb", v, 9'b00000_00_10});
    v = idle; v.wb_rw = 1; v.wb_wr = 7; v.ex_rt = 7;
                                           tbl.push_back('{"fwd_b_wb", v, 9'b00000_00_01});
    v = idle; v.mem_rw = 1; v.mem_m2r = 1; v.rdy = 1; v.mem_wr = 7; v.wb_rw = 1; v.wb_wr = 7; v.ex_rt = 7;
                                           tbl.push_back('{"fwd_b_mem_load", v, 9'b00000_00_01});
    v = idle; v.mem_rw = 1; v.mem_wr = 0; v.wb_rw = 1; v.ex_rs = 0;
                                           tbl.push_back('{"fwd_r0", v, 9'b00000_00_00});
    v = idle; v.mem_rw = 1; v.mem_wr = 3; v.ex_rs = 3; v.ex_rt = 3;
                                           tbl.push_back('{"fwd_ab_mem", v, 9'b00000_10_10});
    v = idle; v.wb_wr = 7; v.ex_rt = 7;    tbl.push_back('{"fwd_wb_nowr", v, 9'b00000_00_00});

    // ---------- reset state ----------
    v = lu; v.br = 1; v.mem_rw = 1; v.mem_wr = 5; v.ex_rs = 5; v.mem_m2r = 1;
    drive(v);
    #12;
    chk("reset_outs", outs(), 9'b0);
    chk("reset_cnt", hif.stall_cycles, 0);
    drive(idle);
    @(posedge clk); #1 rst_n = 1'b1;

    foreach (tbl[k]) begin
      cyc(tbl[k].i);
      chk(tbl[k].name, outs(), tbl[k].e);
    end

    // ---------- single load-use increments counter once ----------
    v = idle; v.clr = 1; cyc(v);
    cyc(lu);   chk("t1_stall", outs(), 9'b11100_00_00);
    cyc(idle); chk("t1_cnt", hif.stall_cycles, 1);

    // ---------- freeze lasts MEM_LAT-1 cycles ----------
    v = idle; v.clr = 1; cyc(v);
    for (int c = 0; c < 3; c++) begin
      cyc(trig); chk($sformatf("frz_c%0d", c), outs(), 9'b00001_00_00);
    end
    cyc(trig); chk("frz_exit", outs(), 9'b0);
    cyc(idle); chk("frz_after", outs(), 9'b0);
    chk("frz_cnt", hif.stall_cycles, 3);

    // ---------- early mem_ready ends freeze after one cycle ----------
    cyc(trig); chk("early_c0", outs(), 9'b00001_00_00);
    v = trig; v.rdy = 1;
    cyc(v);    chk("early_c1", outs(), 9'b0);
    cyc(idle); chk("early_after", outs(), 9'b0);

    // ---------- branch and load-use held off by freeze ----------
    v = lu; v.br = 1; v.mem_m2r = 1; v.rdy = 0;
    for (int c = 0; c < 3; c++) begin
      cyc(v); chk($sformatf("brfrz_c%0d", c), outs(), 9'b00001_00_00);
    end
    cyc(v); chk("brfrz_release", outs(), 9'b00110_00_00);
    cyc(idle);

    // ---------- saturation and clear ----------
    v = idle; v.clr = 1; cyc(v);
    for (int c = 0; c < 20; c++) cyc(lu);
    cyc(idle); chk("sat_cnt", hif.stall_cycles, 15);
    v = lu; v.clr = 1; cyc(v);
    chk("clr_stall_outs", outs(), 9'b11100_00_00);
    cyc(idle); chk("clr_cnt", hif.stall_cycles, 0);

    // ---------- async reset mid-WAIT ----------
    cyc(lu);
    cyc(trig); chk("rstw_c0", outs(), 9'b00001_00_00);
    cyc(trig); chk("rstw_c1", outs(), 9'b00001_00_00);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_freeze", hif.freeze, 0);
    chk("rstw_cnt", hif.stall_cycles, 0);
    @(posedge clk); #1 drive(idle);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("rstw_after", outs(), 9'b0);

    // ---------- random traffic vs model ----------
    age = -1; mcnt = 0;
    for (int n = 0; n < 400; n++) begin
      v.id_rs   = AW'($urandom_range(0, 3)); v.id_rt = AW'($urandom_range(0, 3));
      v.use_rs  = 1'($urandom);  v.use_rt = 1'($urandom);
      v.ex_m2r  = 1'($urandom);  v.ex_wr = AW'($urandom_range(0, 3));
      v.ex_rs   = AW'($urandom_range(0, 3)); v.ex_rt = AW'($urandom_range(0, 3));
      v.br      = ($urandom_range(0, 5) == 0);
      v.mem_rw  = 1'($urandom);  v.mem_m2r = ($urandom_range(0, 2) == 0);
      v.mem_wr  = AW'($urandom_range(0, 3));
      v.rdy     = ($urandom_range(0, 3) == 0);
      v.wb_rw   = 1'($urandom);  v.wb_wr = AW'($urandom_range(0, 3));
      v.clr     = ($urandom_range(0, 15) == 0);
      cyc(v);
      ref_model(v, age, e, nage, inc);
      chk($sformatf("rnd%0d_outs", n), outs(), e);
      chk($sformatf("rnd%0d_cnt", n), hif.stall_cycles, mcnt);
      age = nage;
      if (v.clr) mcnt = 0;
      else if (inc && mcnt < 15) mcnt++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
